// File: rtl/fetch_pkg.sv
// Shared fetch-stage constants: address widths, PC reset value and the
// word-to-byte shift used by branch and jump targets.
package fetch_pkg;

  localparam int WIDTH     = 32;
  localparam int J_WIDTH   = 26;
  localparam int EXT_WIDTH = J_WIDTH + 2;
  localparam int SHIFT_AMT = 2;

  localparam logic [31:0] PC_RESET = 32'h0000_0000;

endpackage : fetch_pkg

// File: rtl/extensor_signo.sv
// Generic sign extender: replicates the MSB of value up to width_out bits.
module extensor_signo #(
  parameter int width_in  = 26,
  parameter int width_out = 28
) (
  input  logic [width_in-1:0]  value,
  output logic [width_out-1:0] extended
);

  assign extended = {{(width_out - width_in){value[width_in-1]}}, value};

endmodule : extensor_signo

// File: rtl/mux2.sv
// Two-input multiplexer: s=1 selects a, s=0 selects b.
module mux2 #(
  parameter int width = 32
) (
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             s,
  output logic [width-1:0] out
);

  assign out = s ? a : b;

endmodule : mux2

// File: rtl/buffer_bajada.sv
// Next-PC selector for the fetch stage: picks sequential, branch or jump
// target and registers it on the falling edge of clk_b.
module buffer_bajada #(
  parameter int WIDTH     = fetch_pkg::WIDTH,
  parameter int J_WIDTH   = fetch_pkg::J_WIDTH,
  parameter int EXT_WIDTH = fetch_pkg::EXT_WIDTH
) (
  input  logic               clk_b,
  input  logic               rst,
  input  logic [WIDTH-1:0]   pc_plus4,
  input  logic [WIDTH-1:0]   signal_extended,
  input  logic               be,
  input  logic [J_WIDTH-1:0] j_address,
  input  logic               jump,
  output logic [WIDTH-1:0]   out
);

  import fetch_pkg::*;

  logic [EXT_WIDTH-1:0] j_ext;
  logic [EXT_WIDTH-1:0] j_sh;
  logic [WIDTH-1:0]     jump_target;
  logic [WIDTH-1:0]     branch_target;
  logic [WIDTH-1:0]     branch_sel;
  logic [WIDTH-1:0]     next_pc;

  extensor_signo #(
    .width_in  (J_WIDTH),
    .width_out (EXT_WIDTH)
  ) u_ext (
    .value    (j_address),
    .extended (j_ext)
  );

  // The shift pushes the replicated sign bits out, so the field lands as
  // {j_address, 2'b00} and the upper PC bits come from pc_plus4 untouched.
  assign j_sh          = j_ext << SHIFT_AMT;
  assign jump_target   = {pc_plus4[WIDTH-1:EXT_WIDTH], j_sh};
  assign branch_target = pc_plus4 + (signal_extended << SHIFT_AMT);

  mux2 #(.width(WIDTH)) u_branch_mux (
    .a   (branch_target),
    .b   (pc_plus4),
    .s   (be),
    .out (branch_sel)
  );

  // Jump is the outer mux so it wins when be and jump are both set.
  mux2 #(.width(WIDTH)) u_jump_mux (
    .a   (jump_target),
    .b   (branch_sel),
    .s   (jump),
    .out (next_pc)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(negedge clk_b) begin
    if (rst) out <= WIDTH'(PC_RESET);
    else     out <= next_pc;
  end

endmodule : buffer_bajada

// File: tb/tb_buffer_bajada.sv
// Self-checking bench for buffer_bajada: directed cases plus randomized
// traffic compared against an arithmetic next-PC model.
module tb_buffer_bajada;

  logic        clk_b = 1'b1;
  logic        rst;
  logic [31:0] pc_plus4;
  logic [31:0] signal_extended;
  logic        be;
  logic [25:0] j_address;
  logic        jump;
  logic [31:0] out;

  int tests  = 0;
  int failed = 0;

  logic [31:0] held;

  buffer_bajada dut (
    .clk_b           (clk_b),
    .rst             (rst),
    .pc_plus4        (pc_plus4),
    .signal_extended (signal_extended),
    .be              (be),
    .j_address       (j_address),
    .jump            (jump),
    .out             (out)
  );

  always #5 clk_b = ~clk_b;

  // Reference: jump region keeps top nibble of PC+4; branch offset is in words.
  function automatic logic [31:0] model_next(input logic r, input logic [31:0] pc,
                                             input logic [31:0] off, input logic b,
                                             input logic [25:0] ja, input logic j);
    logic [63:0] sum;
    if (r) return 32'h0;
    if (j) return (pc & 32'hF000_0000) | (32'(ja) * 32'd4);
    if (b) begin
      sum = 64'(pc) + 64'(off) * 64'd4;
      return sum[31:0];
    end
    return pc;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic [31:0] off,
                       input logic b, input logic [25:0] ja, input logic j);
    rst = r; pc_plus4 = pc; signal_extended = off; be = b; j_address = ja; jump = j;
  endtask

  // Capture on the next falling edge and compare just after it.
  task automatic step(input string tag);
    logic [31:0] exp;
    exp = model_next(rst, pc_plus4, signal_extended, be, j_address, jump);
    @(negedge clk_b);
    #1;
    check(tag, out, exp);
  endtask

  initial begin
    drive(1'b1, 32'h0, 32'h0, 1'b0, 26'h3FF_FFFF, 1'b1);
    step("reset_with_jump");

    drive(1'b0, 32'h0000_0004, 32'h0, 1'b0, 26'h0, 1'b0);
    step("first_sequential");

    drive(1'b0, 32'h0000_0010, 32'h0000_0003, 1'b1, 26'h0, 1'b0);
    step("branch_forward");
    check("branch_forward_const", out, 32'h0000_001C);

    drive(1'b0, 32'h0000_0010, 32'hFFFF_FFFE, 1'b1, 26'h0, 1'b0);
    step("branch_backward");
    check("branch_backward_const", out, 32'h0000_0008);

    drive(1'b0, 32'hA000_0008, 32'h0, 1'b0, 26'h200_0001, 1'b1);
    step("jump_sign_field");
    check("jump_sign_field_const", out, 32'hA800_0004);

    drive(1'b0, 32'h0000_0100, 32'h0000_0010, 1'b1, 26'h40, 1'b1);
    step("jump_priority");
    check("jump_priority_const", out, 32'h0000_0100);

    drive(1'b0, 32'hFFFF_FFFC, 32'h0000_0002, 1'b1, 26'h0, 1'b0);
    step("branch_wrap");
    check("branch_wrap_const", out, 32'h0000_0004);

    drive(1'b0, 32'h1234_5678, 32'h0000_0001, 1'b1, 26'h15, 1'b0);
    step("pre_reset_branch");
    drive(1'b1, 32'h1234_5678, 32'h0000_0001, 1'b1, 26'h15, 1'b1);
    step("mid_reset");
    drive(1'b0, 32'h0000_0040, 32'h0, 1'b0, 26'h0, 1'b0);
    step("post_reset_capture");

    // Edge sensitivity: two input changes between falling edges, rising edge in between.
    held = out;
    drive(1'b0, 32'h5555_0000, 32'h0000_0100, 1'b1, 26'h0, 1'b0);
    #2;
    drive(1'b0, 32'h0000_2000, 32'h0, 1'b0, 26'h123, 1'b1);
    #1;
    check("hold_before_rise", out, held);
    @(posedge clk_b);
    #1;
    check("hold_after_rise", out, held);
    step("update_after_fall");
    check("update_after_fall_const", out, 32'h0000_048C);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] off;
      off = ($urandom_range(0, 1) == 0) ? 32'($signed($urandom_range(0, 16'hFFFF) & 32'hFFFF) <<< 16 >>> 16)
                                        : $urandom;
      off = ($urandom_range(0, 1) == 0) ? {{16{off[15]}}, off[15:0]} : off;
      drive(($urandom_range(0, 15) == 0), $urandom, off, 1'($urandom),
            26'($urandom), 1'($urandom));
      step("random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule : tb_buffer_bajada
